// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the sync_fifo_p family.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                   input int unsigned af, input int unsigned ae);
    return (width >= 1) && (depth >= 4) && is_pow2(depth) &&
           (af >= 1) && (af <= depth) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: synchronous write port, combinational read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised single-clock FIFO with threshold flags, fill level, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is registered.
module sync_fifo_p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      rd,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo_p: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] rdata;
  logic             wa, ra;

  assign full         = (count == FULL_L);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign wa = wr && !full;
  assign ra = rd && !empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wa && !flush),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      if (wa && !ra)      count <= count + 1'b1;
      else if (ra && !wa) count <= count - 1'b1;
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign dout = rdata;
`else
  // Flush leaves dout untouched, so only an accepted non-flush read loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             dout <= '0;
    else if (!flush && ra)  dout <= rdata;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_p.sv
// Scoreboard bench for sync_fifo_p (DEPTH=16, WIDTH=8), both read modes.
module tb_sync_fifo_p;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr, rd;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] sb[$];
  logic [7:0] last_dout;
  logic       m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_p #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags();
    int unsigned n;
    n = sb.size();
    check("count", 32'(count), n);
    check("full", 32'(full), 32'(n == 16));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= 14));
    check("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock cycle of stimulus; the model predicts from the pre-edge state.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic fl);
    logic mfull, mempty, exp_wa, exp_ra;
    logic [7:0] popped;
    popped = '0;
    wr = w; din = d; rd = r; flush = fl;
    mfull  = (sb.size() == 16);
    mempty = (sb.size() == 0);
    exp_wa = w && !mfull && !fl;
    exp_ra = r && !mempty && !fl;
`ifdef FIFO_FWFT_EN
    if (!mempty) begin
      #1;
      check("dout_fwft", 32'(dout), 32'(sb[0]));
    end
`endif
    if (exp_ra) popped = sb.pop_front();
    if (exp_wa) sb.push_back(d);
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && mfull)  m_ovf = 1'b1;
      if (r && mempty) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
`ifndef FIFO_FWFT_EN
    if (exp_ra) last_dout = popped;
    check("dout", 32'(dout), 32'(last_dout));
`endif
    check_flags();
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    m_ovf = 1'b0; m_udf = 1'b0; last_dout = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_flags();
    check("dout_reset", 32'(dout), 32'h0);

    // Fill to full, then a dropped write
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);

    // Drain, then underflow read; dout holds the last value
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check("dout_hold", 32'(dout), 32'h0F);
`endif

    // Steady state at count 5 with simultaneous wr/rd; pointers wrap
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);

    // Full with wr&&rd: read wins, overflow sets
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);

    // Empty with wr&&rd: write wins, underflow sets
    while (sb.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent write is ignored
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    cycle(1'b1, 8'h13, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Async reset between edges at count 8
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0; last_dout = '0;
    #1;
    check_flags();
`ifndef FIFO_FWFT_EN
    check("dout_async_reset", 32'(dout), 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
